// File: rtl/vga_term_ctrl_if.sv
// Character-input, clear-request and video-RAM write bundle of the terminal controller.
// The host side drives characters; the controller side drives VRAM writes and status.
interface vga_term_ctrl_if;
   logic [6:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic       clr_req;
   logic [9:0] vram_addr;
   logic [5:0] vram_data;
   logic       vram_we;
   logic [4:0] top_row;
   logic [5:0] cur_col;
   logic [4:0] cur_row;
   logic       cursor_on;
   logic       busy;

   modport master (
      output char_in, char_valid, clr_req,
      input  char_ready, vram_addr, vram_data, vram_we,
             top_row, cur_col, cur_row, cursor_on, busy
   );

   modport slave (
      input  char_in, char_valid, clr_req,
      output char_ready, vram_addr, vram_data, vram_we,
             top_row, cur_col, cur_row, cursor_on, busy
   );
endinterface

// File: rtl/vga_term_ctrl.sv
// Text terminal controller: turns an ASCII stream into VRAM cell writes with
// wrap, newline, hardware scrolling via a top-row offset, screen clear and cursor blink.
module vga_term_ctrl #(
   parameter int unsigned COLS      = 40,
   parameter int unsigned ROWS      = 24,
   parameter int unsigned BLINK_DIV = 12500000
) (
   input logic           clk,
   input logic           rst_n,
   vga_term_ctrl_if.slave term_io
);
   localparam int unsigned CELLS = COLS * ROWS;
   localparam int unsigned CNT_W = $clog2(CELLS + 1);
   localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [5:0]  SPACE = 6'b100000;

   typedef enum logic [2:0] {CLEAR, IDLE, WRITE, NEWLINE, SCROLL_CLR} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       top_row_q;
   logic [4:0]       cur_row_q;
   logic [5:0]       cur_col_q;
   logic [9:0]       addr_q;
   logic [5:0]       data_q;
   logic             we_q;
   logic             ready_q;
   logic             busy_q;
   logic             cursor_q;
   logic             pend_q;
   logic [BLK_W-1:0] blink_q;

   logic [5:0] row_sum_c;
   logic [4:0] phys_row_c;
   logic [9:0] cell_addr_c;
   logic [9:0] row_base_c;
   logic [4:0] top_row_d;
   logic       clr_c;
   logic       accept_c;
   logic       printable_c;
   logic       ready_d;

   // Cursor cell address in the scrolled VRAM, plus the row freed by a scroll.
   always_comb begin
      row_sum_c   = 6'(top_row_q) + 6'(cur_row_q);
      phys_row_c  = (row_sum_c >= 6'(ROWS)) ? 5'(row_sum_c - 6'(ROWS)) : 5'(row_sum_c);
      cell_addr_c = 10'(32'(phys_row_c) * COLS + 32'(cur_col_q));
      row_base_c  = 10'(32'(top_row_q) * COLS);
      top_row_d   = (top_row_q == 5'(ROWS - 1)) ? 5'd0 : top_row_q + 5'd1;
      clr_c       = term_io.clr_req | pend_q;
      accept_c    = (state_q == IDLE) & ready_q & term_io.char_valid & ~clr_c;
      printable_c = term_io.char_in[6] | term_io.char_in[5];
      ready_d     = ~clr_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         top_row_q <= '0;
         cur_row_q <= '0;
         cur_col_q <= '0;
         addr_q    <= '0;
         data_q    <= SPACE;
         we_q      <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b1;
         cursor_q  <= 1'b1;
         blink_q   <= '0;
         pend_q    <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         pend_q <= pend_q | term_io.clr_req;

         // Blink runs freely but restarts in the visible phase on every accepted character.
         if (accept_c) begin
            cursor_q <= 1'b1;
            blink_q  <= '0;
         end else if (blink_q == BLK_W'(BLINK_DIV - 1)) begin
            cursor_q <= ~cursor_q;
            blink_q  <= '0;
         end else begin
            blink_q  <= blink_q + BLK_W'(1);
         end

         case (state_q)
            CLEAR: begin
               if (cnt_q == CNT_W'(CELLS)) begin
                  state_q   <= IDLE;
                  top_row_q <= '0;
                  cur_row_q <= '0;
                  cur_col_q <= '0;
                  ready_q   <= ready_d;
                  busy_q    <= 1'b0;
               end else begin
                  we_q   <= 1'b1;
                  addr_q <= 10'(cnt_q);
                  data_q <= SPACE;
                  cnt_q  <= cnt_q + CNT_W'(1);
               end
            end
            IDLE: begin
               if (clr_c) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  pend_q  <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (accept_c) begin
                  if (printable_c) begin
                     state_q <= WRITE;
                     we_q    <= 1'b1;
                     addr_q  <= cell_addr_c;
                     data_q  <= {~term_io.char_in[6], term_io.char_in[4:0]};
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end else if (term_io.char_in == 7'h0D) begin
                     state_q <= NEWLINE;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
            end
            WRITE: begin
               // The last column stays put; NEWLINE returns it to zero.
               if (cur_col_q == 6'(COLS - 1)) begin
                  state_q <= NEWLINE;
               end else begin
                  cur_col_q <= cur_col_q + 6'd1;
                  state_q   <= IDLE;
                  ready_q   <= ready_d;
                  busy_q    <= 1'b0;
               end
            end
            NEWLINE: begin
               cur_col_q <= '0;
               if (cur_row_q != 5'(ROWS - 1)) begin
                  cur_row_q <= cur_row_q + 5'd1;
                  state_q   <= IDLE;
                  ready_q   <= ready_d;
                  busy_q    <= 1'b0;
               end else begin
                  // Old top physical row becomes the new bottom row and is blanked.
                  top_row_q <= top_row_d;
                  state_q   <= SCROLL_CLR;
                  we_q      <= 1'b1;
                  addr_q    <= row_base_c;
                  data_q    <= SPACE;
                  cnt_q     <= CNT_W'(1);
               end
            end
            SCROLL_CLR: begin
               if (cnt_q == CNT_W'(COLS)) begin
                  state_q <= IDLE;
                  ready_q <= ready_d;
                  busy_q  <= 1'b0;
               end else begin
                  we_q   <= 1'b1;
                  addr_q <= addr_q + 10'd1;
                  data_q <= SPACE;
                  cnt_q  <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign term_io.char_ready = ready_q;
   assign term_io.vram_addr  = addr_q;
   assign term_io.vram_data  = data_q;
   assign term_io.vram_we    = we_q;
   assign term_io.top_row    = top_row_q;
   assign term_io.cur_col    = cur_col_q;
   assign term_io.cur_row    = cur_row_q;
   assign term_io.cursor_on  = cursor_q;
   assign term_io.busy       = busy_q;
endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl: clear, writes, wrap, newline, scroll,
// deferred clear, blink and mid-clear reset, with hand-computed expectations.
module tb_vga_term_ctrl;
   localparam int unsigned COLS  = 40;
   localparam int unsigned ROWS  = 24;
   localparam int unsigned BLINK = 16;
   localparam logic [5:0]  SP    = 6'b100000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   vga_term_ctrl_if term_if ();

   vga_term_ctrl #(
      .COLS      (COLS),
      .ROWS      (ROWS),
      .BLINK_DIV (BLINK)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .term_io (term_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (term_if.char_ready !== 1'b1 && n < 2000) begin
         step();
         n++;
      end
      check(tag, 32'(term_if.char_ready), 32'd1);
   endtask

   task automatic send_char(input logic [6:0] c);
      wait_ready("send_ready");
      term_if.char_in    = c;
      term_if.char_valid = 1'b1;
      step();
      term_if.char_valid = 1'b0;
   endtask

   // Expects n consecutive writes base..base+n-1 of data d, then a write-free cycle.
   task automatic expect_writes(input string tag, input int base, input int n,
                                input logic [5:0] d, input int pulse_at);
      int errs = 0;
      int w    = 0;
      while (term_if.vram_we !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      for (int k = 0; k < n; k++) begin
         if (term_if.vram_we !== 1'b1 || term_if.vram_addr !== 10'(base + k) ||
             term_if.vram_data !== d)
            errs++;
         term_if.clr_req = (k == pulse_at);
         step();
      end
      term_if.clr_req = 1'b0;
      if (term_if.vram_we !== 1'b0) errs++;
      check({tag, "_errs"}, 32'(errs), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int e;
      int n;
      term_if.char_in    = '0;
      term_if.char_valid = 1'b0;
      term_if.clr_req    = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();

      check("rst_we",     32'(term_if.vram_we),    32'd0);
      check("rst_addr",   32'(term_if.vram_addr),  32'd0);
      check("rst_data",   32'(term_if.vram_data),  32'(SP));
      check("rst_ready",  32'(term_if.char_ready), 32'd0);
      check("rst_busy",   32'(term_if.busy),       32'd1);
      check("rst_cursor", 32'(term_if.cursor_on),  32'd1);
      check("rst_top",    32'(term_if.top_row),    32'd0);

      rst_n = 1'b1;
      expect_writes("clear0", 0, 960, SP, -1);
      check("clear0_ready", 32'(term_if.char_ready), 32'd1);
      check("clear0_busy",  32'(term_if.busy),       32'd0);

      // 'A' at (0,0), then cursor blink hold and toggle.
      send_char(7'h41);
      check("a_we",    32'(term_if.vram_we),    32'd1);
      check("a_addr",  32'(term_if.vram_addr),  32'd0);
      check("a_data",  32'(term_if.vram_data),  32'd1);
      check("a_ready", 32'(term_if.char_ready), 32'd0);
      step();
      check("a_ready_back", 32'(term_if.char_ready), 32'd1);
      check("a_col",        32'(term_if.cur_col),    32'd1);
      e = (term_if.cursor_on !== 1'b1) ? 1 : 0;
      for (int i = 2; i < 16; i++) begin
         step();
         if (term_if.cursor_on !== 1'b1) e++;
      end
      check("blink_hold", 32'(e), 32'd0);
      step();
      check("blink_off", 32'(term_if.cursor_on), 32'd0);
      repeat (16) step();
      check("blink_on", 32'(term_if.cursor_on), 32'd1);

      // Clear request wins over a simultaneous character.
      term_if.clr_req    = 1'b1;
      term_if.char_in    = 7'h43;
      term_if.char_valid = 1'b1;
      step();
      term_if.clr_req    = 1'b0;
      term_if.char_valid = 1'b0;
      check("clr_busy",  32'(term_if.busy),       32'd1);
      check("clr_ready", 32'(term_if.char_ready), 32'd0);
      expect_writes("clear1", 0, 960, SP, -1);
      check("clear1_col", 32'(term_if.cur_col), 32'd0);

      // Full row of 'B' wraps to the next line.
      e = 0;
      for (int k = 0; k < 40; k++) begin
         send_char(7'h42);
         if (term_if.vram_we !== 1'b1 || term_if.vram_addr !== 10'(k) ||
             term_if.vram_data !== 6'b000010)
            e++;
      end
      check("row_fill", 32'(e), 32'd0);
      wait_ready("wrap_ready");
      check("wrap_row", 32'(term_if.cur_row), 32'd1);
      check("wrap_col", 32'(term_if.cur_col), 32'd0);

      e = 0;
      for (int k = 0; k < 5; k++) begin
         send_char(7'h20);
         if (term_if.vram_we !== 1'b1 || term_if.vram_addr !== 10'(40 + k) ||
             term_if.vram_data !== SP)
            e++;
      end
      check("spaces", 32'(e), 32'd0);
      wait_ready("sp_ready");
      check("sp_col", 32'(term_if.cur_col), 32'd5);

      send_char(7'h0D);
      check("cr_nowrite", 32'(term_if.vram_we), 32'd0);
      wait_ready("cr_ready");
      check("cr_row", 32'(term_if.cur_row), 32'd2);
      check("cr_col", 32'(term_if.cur_col), 32'd0);

      // Walk down to the last row, then scroll.
      for (int k = 0; k < 21; k++) send_char(7'h0D);
      wait_ready("bottom_ready");
      check("bottom_row", 32'(term_if.cur_row), 32'd23);
      check("bottom_top", 32'(term_if.top_row), 32'd0);
      send_char(7'h0D);
      expect_writes("scroll0", 0, 40, SP, -1);
      check("scroll0_top", 32'(term_if.top_row), 32'd1);
      check("scroll0_row", 32'(term_if.cur_row), 32'd23);
      check("scroll0_col", 32'(term_if.cur_col), 32'd0);
      send_char(7'h41);
      check("post_scroll_we",   32'(term_if.vram_we),   32'd1);
      check("post_scroll_addr", 32'(term_if.vram_addr), 32'd0);
      check("post_scroll_data", 32'(term_if.vram_data), 32'd1);

      // Clear requested mid-scroll is deferred until the scroll finishes.
      send_char(7'h0D);
      expect_writes("scroll1", 40, 40, SP, 5);
      check("scroll1_ready", 32'(term_if.char_ready), 32'd0);
      expect_writes("clear2", 0, 960, SP, -1);
      check("clear2_top",   32'(term_if.top_row),    32'd0);
      check("clear2_row",   32'(term_if.cur_row),    32'd0);
      check("clear2_col",   32'(term_if.cur_col),    32'd0);
      check("clear2_ready", 32'(term_if.char_ready), 32'd1);

      // Reset in the middle of a clear.
      term_if.clr_req = 1'b1;
      step();
      term_if.clr_req = 1'b0;
      n = 0;
      while ((term_if.vram_we !== 1'b1 || term_if.vram_addr !== 10'd500) && n < 1200) begin
         step();
         n++;
      end
      check("at_500", 32'(term_if.vram_addr), 32'd500);
      rst_n = 1'b0;
      #1;
      check("mid_rst_we",    32'(term_if.vram_we),    32'd0);
      check("mid_rst_addr",  32'(term_if.vram_addr),  32'd0);
      check("mid_rst_data",  32'(term_if.vram_data),  32'(SP));
      check("mid_rst_busy",  32'(term_if.busy),       32'd1);
      check("mid_rst_ready", 32'(term_if.char_ready), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      expect_writes("clear3", 0, 960, SP, -1);

      // Non-CR control code is consumed silently.
      send_char(7'h07);
      check("bel_we",  32'(term_if.vram_we), 32'd0);
      check("bel_col", 32'(term_if.cur_col), 32'd0);
      step();
      check("bel_we2",   32'(term_if.vram_we),    32'd0);
      check("bel_ready", 32'(term_if.char_ready), 32'd1);
      check("bel_busy",  32'(term_if.busy),       32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
